stream_wb_burst_writer: RTL

Upstream feeder for the HyperRAM Wishbone controller. Accepts a 32-bit valid/ready pixel/word stream and buffers it in a small FIFO. Writes it to HyperRAM as Wishbone incrementing bursts (cti 3'b010), starting at a programmed base address and running for a programmed frame length. Its Wishbone master port connects directly to the controller's data slave port.

---
 rtl/stream_wb_burst_writer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/stream_wb_burst_writer.sv
// stream_wb_burst_writer
// ----------------------
// Takes a 32-bit valid/ready word stream, buffers it in a small
// first-word-fall-through FIFO, and writes one frame of words to a Wishbone
// slave. The writes are incrementing bursts (cti 3'b010, last beat 3'b111).
// A frame is described by a base byte address and a length in words.
//
// Ports
//   wb_clk_i, wb_rst_n_i    clock; synchronous active-low reset
//   start_i                 one-cycle pulse, latches base_adr_i / len_words_i (IDLE only)
//   base_adr_i[31:0]        byte address of first word (bits [1:0] ignored)
//   len_words_i[23:0]       frame length in 32-bit words (0 -> immediate done)
//   busy_o                  frame in progress
//   done_o                  one-cycle pulse after the final ack of a frame
//   s_data_i/s_valid_i/s_ready_o   input word stream
//   wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
//   wb_cti_o, wb_bte_o, wb_ack_i   Wishbone write master
module stream_wb_burst_writer #(
  parameter int BURST_LEN = 4,  // power of two, <= 2**FIFO_AW
  parameter int FIFO_AW   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [23:0] len_words_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;            // count spans 0..DEPTH inclusive
  localparam int BW    = $clog2(BURST_LEN) + 1;  // beat counter spans 0..BURST_LEN
  localparam logic [23:0]   BURST_LEN_L = 24'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [23:0]   in_rem_q, in_rem_d;   // words still to accept from the stream
  logic [23:0]   wr_rem_q, wr_rem_d;   // words still to write on the bus
  logic [BW-1:0] beat_q, beat_d;       // beats left in the current burst
  logic [BW-1:0] bsz;
  logic          cyc_q, cyc_d;
  logic [2:0]    cti_q, cti_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Address bits [1:0] are forced to zero; tie them off explicitly.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^base_adr_i[1:0];

  // ---------------------------------------------------------------------------
  // FIFO (first-word-fall-through: the head is always visible on wb_dat_o)
  // ---------------------------------------------------------------------------
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               fifo_full, push, pop;

  assign fifo_full = (count_q == DEPTH_C);
  assign s_ready_o = ((state_q == ST_WAIT) || (state_q == ST_BURST)) &&
                     !fifo_full && (in_rem_q != 24'd0);
  assign push      = s_valid_i & s_ready_o;
  // A burst is only launched with bsz words present, so pop never underflows.
  assign pop       = (state_q == ST_BURST) & wb_ack_i;
  assign wb_dat_o  = mem[rd_ptr_q];

  // NOTE: the storage array is deliberately not reset; only the pointers and
  // count need a known value, and a reset on the array would cost a reset net
  // per bit and block RAM inference.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q] <= s_data_i;
  end

  // NOTE: every sequential process uses non-blocking (<=) assignments so that
  // all registers update together from the values present before the edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;  // idle, or push and pop together: occupancy unchanged
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst control FSM
  // ---------------------------------------------------------------------------
  assign bsz = (wr_rem_q >= BURST_LEN_L) ? BW'(BURST_LEN) : wr_rem_q[BW-1:0];

  // NOTE: every variable written here receives a default first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    in_rem_d = in_rem_q;
    wr_rem_d = wr_rem_q;
    beat_d   = beat_q;

    if (push) in_rem_d = in_rem_q - 24'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_words_i == 24'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_WAIT;
            adr_d    = {base_adr_i[31:2], 2'b00};
            in_rem_d = len_words_i;
            wr_rem_d = len_words_i;
          end
        end
      end
      ST_WAIT: begin
        if (count_q >= CW'(bsz)) begin
          state_d = ST_BURST;
          beat_d  = bsz;
        end
      end
      ST_BURST: begin
        if (wb_ack_i) begin
          adr_d    = adr_q + 32'd4;
          wr_rem_d = wr_rem_q - 24'd1;
          beat_d   = beat_q - BW'(1);
          if (beat_q == BW'(1)) state_d = (wr_rem_q == 24'd1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus and status outputs are registered from the next state, so cyc drops
    // on the same edge that takes the last ack.
    cyc_d  = (state_d == ST_BURST);
    cti_d  = !cyc_d ? 3'b000 : ((beat_d == BW'(1)) ? 3'b111 : 3'b010);
    busy_d = (state_d == ST_WAIT) || (state_d == ST_BURST);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      in_rem_q <= '0;
      wr_rem_q <= '0;
      beat_q   <= '0;
      cyc_q    <= 1'b0;
      cti_q    <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      in_rem_q <= in_rem_d;
      wr_rem_q <= wr_rem_d;
      beat_q   <= beat_d;
      cyc_q    <= cyc_d;
      cti_q    <= cti_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q;
  assign wb_sel_o = {4{cyc_q}};
  assign wb_cti_o = cti_q;
  assign wb_bte_o = 2'b00;
  assign wb_adr_o = adr_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
